mem_access_stage: RTL and testbench

//  MEM stage, directly downstream of the EX/MEM pipeline register. Consumes the registered execute_data_t.

---
 rtl/mem_access_stage.sv | 201 ++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM stage: data-bus handshake, byte-lane alignment and load extension.
// Optional MISALIGN_CHECK_EN: drop misaligned accesses and flag them.
package mem_pkg;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] msize;
        logic       mem_unsigned;
    } ctl_t;

    typedef struct packed {
        logic [63:0] pc;
        ctl_t        ctl;
        logic [4:0]  dst;
        logic        is_bubble;
        logic [11:0] csr_addr;
        logic        csr_we;
        logic [63:0] result;
        logic [63:0] wdata;
    } execute_data_t;

    typedef struct packed {
        logic [63:0] pc;
        ctl_t        ctl;
        logic [4:0]  dst;
        logic        is_bubble;
        logic [11:0] csr_addr;
        logic        csr_we;
        logic [63:0] result;
    } memory_data_t;

endpackage

module mem_access_stage
    import mem_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  execute_data_t     dataE_in,
    input  logic              stall_ext,
    output logic              dreq_valid,
    output logic [ADDR_W-1:0] dreq_addr,
    output logic [2:0]        dreq_size,
    output logic [7:0]        dreq_strobe,
    output logic [DATA_W-1:0] dreq_data,
    input  logic              dresp_ok,
    input  logic [DATA_W-1:0] dresp_data,
    output memory_data_t      dataM_out,
    output logic              Dwait,
    output logic              misalign
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t            state;
    logic [ADDR_W-1:0] reqAddr;
    logic [2:0]        reqSize;
    logic [7:0]        reqStrobe;
    logic [DATA_W-1:0] reqData;
    logic [DATA_W-1:0] rdataQ;

    logic              memOp;
    logic              misDet;
    logic              issue;
    logic              respNow;
    logic [2:0]        laneOff;
    logic [7:0]        sizeMask;
    logic [7:0]        strobeNext;
    logic [DATA_W-1:0] dataNext;
    logic [DATA_W-1:0] loadRaw;
    logic [DATA_W-1:0] loadShift;
    logic [63:0]       loadVal;
`ifdef MISALIGN_CHECK_EN
    logic [2:0]        alignMask;
`endif

    // Decode the access: lane offset, byte mask, strobe, shifted store data.
    always_comb begin
        memOp   = !dataE_in.is_bubble &&
                  (dataE_in.ctl.mem_read || dataE_in.ctl.mem_write);
        laneOff = dataE_in.result[2:0];
        unique case (dataE_in.ctl.msize)
            2'd0: sizeMask = 8'h01;
            2'd1: sizeMask = 8'h03;
            2'd2: sizeMask = 8'h0F;
            2'd3: sizeMask = 8'hFF;
        endcase
`ifdef MISALIGN_CHECK_EN
        unique case (dataE_in.ctl.msize)
            2'd0: alignMask = 3'd0;
            2'd1: alignMask = 3'd1;
            2'd2: alignMask = 3'd3;
            2'd3: alignMask = 3'd7;
        endcase
        misDet = memOp && ((laneOff & alignMask) != 3'd0);
`else
        misDet = 1'b0;
`endif
        issue   = memOp && !misDet;
        respNow = (state == REQ) && dresp_ok;
        strobeNext = '0;
        dataNext   = '0;
        if (dataE_in.ctl.mem_write) begin
            strobeNext = sizeMask << laneOff;
            dataNext   = dataE_in.wdata << {laneOff, 3'b000};
        end
    end

    // Pick the live or held response, shift to lane 0 and extend.
    always_comb begin
        loadRaw   = (state == HOLD) ? rdataQ : dresp_data;
        loadShift = loadRaw >> {laneOff, 3'b000};
        unique case (dataE_in.ctl.msize)
            2'd0: loadVal = dataE_in.ctl.mem_unsigned ?
                            {56'd0, loadShift[7:0]} :
                            {{56{loadShift[7]}}, loadShift[7:0]};
            2'd1: loadVal = dataE_in.ctl.mem_unsigned ?
                            {48'd0, loadShift[15:0]} :
                            {{48{loadShift[15]}}, loadShift[15:0]};
            2'd2: loadVal = dataE_in.ctl.mem_unsigned ?
                            {32'd0, loadShift[31:0]} :
                            {{32{loadShift[31]}}, loadShift[31:0]};
            2'd3: loadVal = loadShift[63:0];
        endcase
    end

    // Request FSM; request fields are captured at issue and held in REQ.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rdataQ    <= '0;
            reqAddr   <= '0;
            reqSize   <= '0;
            reqStrobe <= '0;
            reqData   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (issue) begin
                        state     <= REQ;
                        reqAddr   <= dataE_in.result[ADDR_W-1:0];
                        reqSize   <= {1'b0, dataE_in.ctl.msize};
                        reqStrobe <= strobeNext;
                        reqData   <= dataNext;
                    end
                end
                REQ: begin
                    if (dresp_ok) begin
                        rdataQ <= dresp_data;
                        state  <= stall_ext ? HOLD : IDLE;
                    end
                end
                HOLD: begin
                    if (!stall_ext) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Drive bus, stall and MEM/WB outputs; reset forces a clean bubble.
    always_comb begin
        dataM_out.pc        = dataE_in.pc;
        dataM_out.ctl       = dataE_in.ctl;
        dataM_out.dst       = dataE_in.dst;
        dataM_out.is_bubble = dataE_in.is_bubble;
        dataM_out.csr_addr  = dataE_in.csr_addr;
        dataM_out.csr_we    = dataE_in.csr_we;
        dataM_out.result    = dataE_in.result;
        if (memOp && dataE_in.ctl.mem_read) dataM_out.result = loadVal;
        if (misDet) begin
            dataM_out.is_bubble     = 1'b1;
            dataM_out.ctl.reg_write = 1'b0;
        end
        dreq_valid  = (state == REQ);
        dreq_addr   = reqAddr;
        dreq_size   = reqSize;
        dreq_strobe = reqStrobe;
        dreq_data   = reqData;
        Dwait       = issue && !respNow && (state != HOLD);
        misalign    = misDet;
        if (reset) begin
            dataM_out           = '0;
            dataM_out.is_bubble = 1'b1;
            dataM_out.pc        = 64'h8000_0000;
            dreq_valid          = 1'b0;
            dreq_addr           = '0;
            dreq_size           = '0;
            dreq_strobe         = '0;
            dreq_data           = '0;
            Dwait               = 1'b0;
            misalign            = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: vector table plus
// hand-written latency, hold, reset and misalign sequences.
module tb_mem_access_stage;
    import mem_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    execute_data_t dataE_in;
    logic          stall_ext;
    logic          dreq_valid;
    logic [63:0]   dreq_addr;
    logic [2:0]    dreq_size;
    logic [7:0]    dreq_strobe;
    logic [63:0]   dreq_data;
    logic          dresp_ok;
    logic [63:0]   dresp_data;
    memory_data_t  dataM_out;
    logic          Dwait;
    logic          misalign;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       name;
        logic [63:0] addr;
        logic [1:0]  msize;
        logic        wr;
        logic        uns;
        logic [63:0] wdata;
        logic [63:0] resp;
        logic [63:0] expRes;
        logic [7:0]  expStrb;
        logic [63:0] expData;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    mem_access_stage #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk),
        .reset(reset),
        .dataE_in(dataE_in),
        .stall_ext(stall_ext),
        .dreq_valid(dreq_valid),
        .dreq_addr(dreq_addr),
        .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe),
        .dreq_data(dreq_data),
        .dresp_ok(dresp_ok),
        .dresp_data(dresp_data),
        .dataM_out(dataM_out),
        .Dwait(Dwait),
        .misalign(misalign)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    function automatic execute_data_t mk(input logic [63:0] addr,
                                         input logic [1:0] msize,
                                         input logic rd, input logic wr,
                                         input logic uns,
                                         input logic [63:0] wdata);
        execute_data_t e;
        e = '0;
        e.pc               = 64'h8000_0100;
        e.dst              = 5'd5;
        e.ctl.reg_write    = !wr;
        e.ctl.mem_read     = rd;
        e.ctl.mem_write    = wr;
        e.ctl.msize        = msize;
        e.ctl.mem_unsigned = uns;
        e.result           = addr;
        e.wdata            = wdata;
        return e;
    endfunction

    function automatic execute_data_t bubble();
        execute_data_t e;
        e = '0;
        e.pc        = 64'h1234;
        e.is_bubble = 1'b1;
        return e;
    endfunction

    function automatic void addV(input string n, input logic [63:0] a,
                                 input logic [1:0] s, input logic w,
                                 input logic u, input logic [63:0] wd,
                                 input logic [63:0] r, input logic [63:0] er,
                                 input logic [7:0] es, input logic [63:0] ed);
        vec_t v;
        v.name = n; v.addr = a; v.msize = s; v.wr = w; v.uns = u;
        v.wdata = wd; v.resp = r; v.expRes = er;
        v.expStrb = es; v.expData = ed;
        vecs.push_back(v);
    endfunction

    task automatic goIdle();
        @(posedge clk); #1;
        dresp_ok  = 1'b0;
        stall_ext = 1'b0;
        dataE_in  = bubble();
    endtask

    task automatic waitReq(input string name);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dreq_valid) break;
        end
        chk({name, "_req_seen"}, 64'(dreq_valid), 64'd1);
    endtask

    task automatic runVec(input vec_t v);
        @(posedge clk); #1;
        dresp_ok  = 1'b0;
        stall_ext = 1'b0;
        dataE_in  = mk(v.addr, v.msize, !v.wr, v.wr, v.uns, v.wdata);
        waitReq(v.name);
        chk({v.name, "_addr"}, dreq_addr, v.addr);
        chk({v.name, "_size"}, 64'(dreq_size), 64'(v.msize));
        chk({v.name, "_strobe"}, 64'(dreq_strobe), 64'(v.expStrb));
        if (v.wr) chk({v.name, "_wdata"}, dreq_data, v.expData);
        @(posedge clk); #1;
        dresp_ok   = 1'b1;
        dresp_data = v.resp;
        @(negedge clk);
        chk({v.name, "_dwait"}, 64'(Dwait), 64'd0);
        chk({v.name, "_result"}, dataM_out.result, v.expRes);
        chk({v.name, "_bubble"}, 64'(dataM_out.is_bubble), 64'd0);
        goIdle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        addV("ld", 64'h8000_1000, 2'd3, 1'b0, 1'b0, 64'h0,
             64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788, 8'h00, 64'h0);
        addV("lb", 64'h8000_1003, 2'd0, 1'b0, 1'b0, 64'h0,
             64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80, 8'h00, 64'h0);
        addV("lbu", 64'h8000_1003, 2'd0, 1'b0, 1'b1, 64'h0,
             64'h0000_0000_8000_0000, 64'h80, 8'h00, 64'h0);
        addV("lh", 64'h8000_1002, 2'd1, 1'b0, 1'b0, 64'h0,
             64'h0000_0000_8001_0000, 64'hFFFF_FFFF_FFFF_8001, 8'h00, 64'h0);
        addV("lhu", 64'h8000_1006, 2'd1, 1'b0, 1'b1, 64'h0,
             64'hBEEF_0000_0000_0000, 64'hBEEF, 8'h00, 64'h0);
        addV("lw", 64'h8000_1004, 2'd2, 1'b0, 1'b0, 64'h0,
             64'h89AB_CDEF_0000_0000, 64'hFFFF_FFFF_89AB_CDEF, 8'h00, 64'h0);
        addV("lwu", 64'h8000_1004, 2'd2, 1'b0, 1'b1, 64'h0,
             64'h89AB_CDEF_0000_0000, 64'h0000_0000_89AB_CDEF, 8'h00, 64'h0);
        addV("lwpos", 64'h8000_1000, 2'd2, 1'b0, 1'b0, 64'h0,
             64'hFFFF_FFFF_7FFF_FFFF, 64'h0000_0000_7FFF_FFFF, 8'h00, 64'h0);
        addV("sh", 64'h8000_1006, 2'd1, 1'b1, 1'b0, 64'hBEEF,
             64'h0, 64'h8000_1006, 8'hC0, 64'hBEEF_0000_0000_0000);
        addV("sb", 64'h8000_1001, 2'd0, 1'b1, 1'b0, 64'hA5,
             64'h0, 64'h8000_1001, 8'h02, 64'hA500);
        addV("sw", 64'h8000_1004, 2'd2, 1'b1, 1'b0, 64'h1234_5678,
             64'h0, 64'h8000_1004, 8'hF0, 64'h1234_5678_0000_0000);
        addV("sd", 64'h8000_1000, 2'd3, 1'b1, 1'b0, 64'h0102_0304_0506_0708,
             64'h0, 64'h8000_1000, 8'hFF, 64'h0102_0304_0506_0708);

        reset      = 1'b1;
        stall_ext  = 1'b0;
        dresp_ok   = 1'b0;
        dresp_data = '0;
        dataE_in   = mk(64'h8000_1000, 2'd3, 1'b1, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        chk("rst_valid", 64'(dreq_valid), 64'd0);
        chk("rst_dwait", 64'(Dwait), 64'd0);
        chk("rst_misalign", 64'(misalign), 64'd0);
        chk("rst_bubble", 64'(dataM_out.is_bubble), 64'd1);
        chk("rst_pc", dataM_out.pc, 64'h8000_0000);
        chk("rst_result", dataM_out.result, 64'h0);
        @(posedge clk); #1;
        dataE_in = bubble();
        @(posedge clk); #1;
        reset = 1'b0;

        // non-memory op passes straight through
        dataE_in = mk(64'hDEAD, 2'd0, 1'b0, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        chk("alu_result", dataM_out.result, 64'hDEAD);
        chk("alu_dwait", 64'(Dwait), 64'd0);
        chk("alu_valid", 64'(dreq_valid), 64'd0);
        chk("alu_regwr", 64'(dataM_out.ctl.reg_write), 64'd1);
        goIdle();

        // ld with response three cycles after the instruction arrives
        @(posedge clk); #1;
        dataE_in = mk(64'h8000_1000, 2'd3, 1'b1, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        chk("lat_c0_dwait", 64'(Dwait), 64'd1);
        chk("lat_c0_valid", 64'(dreq_valid), 64'd0);
        for (int c = 1; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("lat_c%0d_dwait", c), 64'(Dwait), 64'd1);
            chk($sformatf("lat_c%0d_valid", c), 64'(dreq_valid), 64'd1);
            chk($sformatf("lat_c%0d_addr", c), dreq_addr, 64'h8000_1000);
        end
        @(posedge clk); #1;
        dresp_ok   = 1'b1;
        dresp_data = 64'h1122_3344_5566_7788;
        @(negedge clk);
        chk("lat_done_dwait", 64'(Dwait), 64'd0);
        chk("lat_done_result", dataM_out.result, 64'h1122_3344_5566_7788);
        chk("lat_done_pc", dataM_out.pc, 64'h8000_0100);
        chk("lat_done_dst", 64'(dataM_out.dst), 64'd5);
        goIdle();
        @(negedge clk);
        chk("lat_after_valid", 64'(dreq_valid), 64'd0);

        foreach (vecs[i]) runVec(vecs[i]);

        // response lands while the pipe is held by another stall
        @(posedge clk); #1;
        dataE_in = mk(64'h8000_1003, 2'd0, 1'b1, 1'b0, 1'b0, 64'h0);
        waitReq("hold");
        @(posedge clk); #1;
        dresp_ok   = 1'b1;
        stall_ext  = 1'b1;
        dresp_data = 64'h0000_0000_8000_0000;
        @(negedge clk);
        chk("hold_resp_dwait", 64'(Dwait), 64'd0);
        @(posedge clk); #1;
        dresp_ok   = 1'b0;
        dresp_data = 64'hFFFF_FFFF_0000_0000;
        @(negedge clk);
        chk("hold1_valid", 64'(dreq_valid), 64'd0);
        chk("hold1_dwait", 64'(Dwait), 64'd0);
        chk("hold1_result", dataM_out.result, 64'hFFFF_FFFF_FFFF_FF80);
        @(posedge clk); #1;
        stall_ext = 1'b0;
        @(negedge clk);
        chk("hold_rel_valid", 64'(dreq_valid), 64'd0);
        chk("hold_rel_dwait", 64'(Dwait), 64'd0);
        chk("hold_rel_result", dataM_out.result, 64'hFFFF_FFFF_FFFF_FF80);
        goIdle();
        @(negedge clk);
        chk("hold_post_valid", 64'(dreq_valid), 64'd0);

        // reset in the middle of an outstanding request
        @(posedge clk); #1;
        dataE_in = mk(64'h8000_1000, 2'd3, 1'b1, 1'b0, 1'b0, 64'h0);
        waitReq("rstreq");
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_valid", 64'(dreq_valid), 64'd0);
        chk("midrst_dwait", 64'(Dwait), 64'd0);
        chk("midrst_bubble", 64'(dataM_out.is_bubble), 64'd1);
        chk("midrst_pc", dataM_out.pc, 64'h8000_0000);
        @(posedge clk); #1;
        reset      = 1'b0;
        dataE_in   = bubble();
        dresp_ok   = 1'b1;
        dresp_data = 64'h5555;
        @(negedge clk);
        chk("late_resp_valid", 64'(dreq_valid), 64'd0);
        chk("late_resp_dwait", 64'(Dwait), 64'd0);
        @(posedge clk); #1;
        dresp_ok = 1'b0;
        @(negedge clk);
        chk("late_resp_idle", 64'(dreq_valid), 64'd0);
        runVec(vecs[0]);

        // misaligned word load
        @(posedge clk); #1;
        dataE_in = mk(64'h8000_1002, 2'd2, 1'b1, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
`ifdef MISALIGN_CHECK_EN
        chk("mis_flag", 64'(misalign), 64'd1);
        chk("mis_dwait", 64'(Dwait), 64'd0);
        chk("mis_bubble", 64'(dataM_out.is_bubble), 64'd1);
        chk("mis_regwr", 64'(dataM_out.ctl.reg_write), 64'd0);
        @(negedge clk);
        chk("mis_noreq", 64'(dreq_valid), 64'd0);
        goIdle();
`else
        chk("mis_flag", 64'(misalign), 64'd0);
        chk("mis_dwait", 64'(Dwait), 64'd1);
        waitReq("mis");
        chk("mis_addr", dreq_addr, 64'h8000_1002);
        chk("mis_size", 64'(dreq_size), 64'd2);
        @(posedge clk); #1;
        dresp_ok   = 1'b1;
        dresp_data = 64'h0000_CAFE_BABE_0000;
        @(negedge clk);
        chk("mis_result", dataM_out.result, 64'hFFFF_FFFF_CAFE_BABE);
        chk("mis_done_dwait", 64'(Dwait), 64'd0);
        goIdle();
`endif

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
